// File: rtl/memory_cycle.sv
// memory_cycle: RISC-V memory-access stage with internal word-addressed data memory
// and the M/W pipeline register; also drives the writeback result mux.
`default_nettype none

module memory_cycle #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MisalignW,
  output logic [31:0] ResultW
);

  logic [31:0]   r_mem [0:DEPTH-1];
  logic [AW-1:0] w_index;
  logic [31:0]   w_rdata;
  logic          w_addr_misaligned;
  logic          w_misalign;

  logic          r_reg_write;
  logic          r_result_src;
  logic [4:0]    r_rd;
  logic [31:0]   r_pc_plus4;
  logic [31:0]   r_alu_result;
  logic [31:0]   r_read_data;
  logic          r_misalign;

  // Upper address bits are dropped, so accesses wrap modulo 4*DEPTH bytes.
  assign w_index           = ALU_ResultM[AW+1:2];
  assign w_rdata           = r_mem[w_index];
  assign w_addr_misaligned = (ALU_ResultM[1:0] != 2'b00);
  assign w_misalign        = w_addr_misaligned && (MemWriteM || ResultSrcM);

  // Memory is not reset; reset only blocks stores.
  always_ff @(posedge clk) begin
    if (!rst && MemWriteM && !w_addr_misaligned) begin
      r_mem[w_index] <= WriteDataM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_rd         <= 5'd0;
      r_pc_plus4   <= 32'd0;
      r_alu_result <= 32'd0;
      r_read_data  <= 32'd0;
      r_misalign   <= 1'b0;
    end else begin
      r_reg_write  <= RegWriteM;
      r_result_src <= ResultSrcM;
      r_rd         <= RD_M;
      r_pc_plus4   <= PCPlus4M;
      r_alu_result <= ALU_ResultM;
      r_read_data  <= w_rdata;
      r_misalign   <= w_misalign;
    end
  end

  assign RegWriteW   = r_reg_write;
  assign ResultSrcW  = r_result_src;
  assign RD_W        = r_rd;
  assign PCPlus4W    = r_pc_plus4;
  assign ALU_ResultW = r_alu_result;
  assign ReadDataW   = r_read_data;
  assign MisalignW   = r_misalign;
  assign ResultW     = r_result_src ? r_read_data : r_alu_result;

endmodule

`default_nettype wire

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: table vectors, reset sequence and randomized checks against a
// behavioural memory model for memory_cycle.
`default_nettype none

module tb_memory_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALU_ResultM;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
  logic        MisalignW;
  logic [31:0] ResultW;

  int n_pass  = 0;
  int n_total = 0;

  memory_cycle #(.DEPTH(1024), .AW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .PCPlus4W    (PCPlus4W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .MisalignW   (MisalignW),
    .ResultW     (ResultW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] wd;
    logic [31:0] addr;
    logic [31:0] erd;
    bit          crd;
    logic        emis;
  } vec_t;

  vec_t tbl [13];

  logic [31:0] model_mem   [1024];
  bit          model_valid [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " RegWriteW"},   {31'd0, RegWriteW},  32'd0);
    chk({tag, " ResultSrcW"},  {31'd0, ResultSrcW}, 32'd0);
    chk({tag, " RD_W"},        {27'd0, RD_W},       32'd0);
    chk({tag, " PCPlus4W"},    PCPlus4W,            32'd0);
    chk({tag, " ALU_ResultW"}, ALU_ResultW,         32'd0);
    chk({tag, " ReadDataW"},   ReadDataW,           32'd0);
    chk({tag, " MisalignW"},   {31'd0, MisalignW},  32'd0);
    chk({tag, " ResultW"},     ResultW,             32'd0);
  endtask

  // Drive one M-stage instruction, let one edge pass, then check the W outputs.
  task automatic apply(input string tag, input logic we, input logic rw, input logic rs,
                       input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                       input logic [31:0] addr, input logic [31:0] erd, input bit crd,
                       input logic emis);
    MemWriteM   = we;
    RegWriteM   = rw;
    ResultSrcM  = rs;
    RD_M        = rd;
    PCPlus4M    = pc;
    WriteDataM  = wd;
    ALU_ResultM = addr;
    @(posedge clk);
    #1;
    chk({tag, " RegWriteW"},   {31'd0, RegWriteW},  {31'd0, rw});
    chk({tag, " ResultSrcW"},  {31'd0, ResultSrcW}, {31'd0, rs});
    chk({tag, " RD_W"},        {27'd0, RD_W},       {27'd0, rd});
    chk({tag, " PCPlus4W"},    PCPlus4W,            pc);
    chk({tag, " ALU_ResultW"}, ALU_ResultW,         addr);
    chk({tag, " MisalignW"},   {31'd0, MisalignW},  {31'd0, emis});
    if (crd) chk({tag, " ReadDataW"}, ReadDataW, erd);
    if (!rs)      chk({tag, " ResultW"}, ResultW, addr);
    else if (crd) chk({tag, " ResultW"}, ResultW, erd);
  endtask

  initial begin
    //            we    rw    rs    rd    pc       wd            addr          erd           crd emis
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h04, 32'hDEADBEEF, 32'h00000010, 32'h0,        0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 5'd5, 32'h08, 32'h0,        32'h00000010, 32'hDEADBEEF, 1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0C, 32'h11111111, 32'h00000010, 32'hDEADBEEF, 1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 5'd7, 32'h10, 32'h22222222, 32'h00000010, 32'h11111111, 1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 5'd8, 32'h14, 32'h0,        32'h00000010, 32'h22222222, 1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h18, 32'h55555555, 32'h00000010, 32'h22222222, 1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h1C, 32'hAAAAAAAA, 32'h00000012, 32'h55555555, 1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 5'd9, 32'h20, 32'h0,        32'h00000010, 32'h55555555, 1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h24, 32'hCAFEF00D, 32'h00001000, 32'h0,        0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 5'd3, 32'h28, 32'h0,        32'h00000000, 32'hCAFEF00D, 1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 5'd4, 32'h2C, 32'h0,        32'h00000003, 32'hCAFEF00D, 1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 5'd6, 32'h40, 32'h0,        32'h7FFFFFFF, 32'h0,        0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h00, 32'h0,        32'h00000000, 32'hCAFEF00D, 1, 1'b0};

    rst = 1'b1;
    MemWriteM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 1'b0; RD_M = 5'd0;
    PCPlus4M = 32'd0; WriteDataM = 32'd0; ALU_ResultM = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    #3 rst = 1'b0;

    for (int i = 0; i < 13; i++)
      apply($sformatf("vec%0d", i), tbl[i].we, tbl[i].rw, tbl[i].rs, tbl[i].rd, tbl[i].pc,
            tbl[i].wd, tbl[i].addr, tbl[i].erd, tbl[i].crd, tbl[i].emis);

    // Asynchronous reset while W holds a live instruction; a store edge under reset is blocked.
    apply("prerst", 1'b0, 1'b1, 1'b0, 5'd2, 32'h44, 32'h0, 32'h00001234, 32'h0, 0, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    MemWriteM = 1'b1; WriteDataM = 32'h99999999; ALU_ResultM = 32'h10;
    RegWriteM = 1'b1; RD_M = 5'd1; PCPlus4M = 32'h48;
    @(posedge clk);
    #1 check_zero("rst_edge");
    #3 rst = 1'b0;
    apply("post_rst_load", 1'b0, 1'b1, 1'b1, 5'd5, 32'h4C, 32'h0, 32'h00000010,
          32'h55555555, 1, 1'b0);

    // Randomized traffic over a small window of words so stores and loads collide.
    for (int i = 0; i < 1024; i++) model_valid[i] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        we, rw, rs, emis;
      logic [4:0]  rd;
      logic [31:0] pc, wd, addr, erd;
      int          widx;
      bit          crd;
      we   = ($urandom_range(0, 2) == 0);
      rs   = !we && ($urandom_range(0, 1) == 1);
      rw   = !we && ($urandom_range(0, 3) != 0);
      rd   = 5'($urandom);
      pc   = $urandom;
      wd   = $urandom;
      addr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) * 4);
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      widx = int'((addr % 32'd4096) / 32'd4);
      crd  = model_valid[widx];
      erd  = model_mem[widx];
      emis = ((addr % 4) != 0) && (we || rs);
      if (we && (addr % 4) == 0) begin
        model_mem[widx]   = wd;
        model_valid[widx] = 1'b1;
      end
      apply($sformatf("rnd%0d", i), we, rw, rs, rd, pc, wd, addr, erd, crd, emis);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
